pwm_ramp_ctrl: RTL and testbench
================================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: PWM counter width; duty is WIDTH+1 bits, so 2^WIDTH means 100 %.
REQ-002 SHALL have parameter TIMER_WIDTH, default 15: prescale timer width.
REQ-003 SHALL have parameter DWELL_WIDTH, default 8: dwell counter width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 period_tick  in  1  one-cycle pulse at each PWM period boundary.
REQ-007 cfg_valid  in  1  new configuration offered.
REQ-008 cfg_ready  out  1  configuration can be accepted this cycle.
REQ-009 cfg_target  in  WIDTH+1  target duty.
REQ-010 cfg_step  in  WIDTH  duty change per step.
REQ-011 cfg_dwell  in  DWELL_WIDTH  PWM periods per step.
REQ-012 cfg_timer  in  TIMER_WIDTH  prescale value for the PWM timer.
REQ-013 off_req  in  1  pulse: ramp to zero, then go idle.
REQ-014 duty  out  WIDTH+1  registered duty to the PWM datapath.
REQ-015 timer_final_value  out  TIMER_WIDTH  registered prescale value to the PWM datapath.
REQ-016 busy  out  1  high in RAMP.
REQ-017 done  out  1  one-cycle pulse when duty reaches target.

Function
REQ-018 States SHALL be IDLE, RAMP and HOLD.
REQ-019 Handshake: transfer occurs when cfg_valid && cfg_ready; cfg_ready = (state != RAMP) && !off_req.
REQ-020 On transfer: latch target, step and dwell; timer_final_value <= cfg_timer in the same edge; clear the dwell count.
REQ-021 Latched values:
- target clamped to 2^WIDTH when larger;
- step 0 stored as 1;
- dwell 0 stored as 1.
REQ-022 Transitions on transfer:
- IDLE -> RAMP, or -> HOLD with a done pulse if the clamped target equals current duty;
- HOLD -> the same choice.
REQ-023 RAMP stepping:
- each period_tick increments the dwell count;
- when the count reaches the latched dwell (checked in the same cycle as the tick), the count clears and duty moves one step toward target;
- duty is clamped to target, so no overshoot and no wrap below 0 or above 2^WIDTH.
REQ-024 RAMP exit: the cycle after duty becomes equal to target, the block enters HOLD with done=1 for exactly one cycle.
REQ-025 Off request: off_req in HOLD or RAMP sets target to 0 and an off flag, and enters or stays in RAMP; off_req in IDLE is ignored.
REQ-026 Off completion: when duty reaches 0 with the off flag set, the block enters IDLE, pulses done, and clears the flag; timer_final_value is held.
REQ-027 Simultaneous events:
- off_req with cfg_valid: off_req wins and no transfer occurs;
- period_tick ignored outside RAMP.
REQ-028 Latency: duty changes on the clk edge that samples the dwell-completing period_tick.

Reset
REQ-029 On rst: state=IDLE, duty=0, timer_final_value=0, busy=0, done=0, dwell count=0, off flag=0, latched step=1, dwell=1, target=0.
REQ-030 rst asserted mid-RAMP SHALL take effect at the next edge regardless of other inputs; cfg_ready=1 the cycle after release.

Structure
REQ-031 Shared package SHALL hold the state encoding (IDLE=0, RAMP=1, HOLD=2) and the default parameter constants.
REQ-032 The dwell counter MAY be one sub-module, pwm_dwell_cnt: tick in, terminal count in, done-pulse out, synchronous clear.
REQ-033 Top level SHALL instantiate no PWM; it drives the duty and timer_final_value ports of an existing PWM instance.

Verification
REQ-034 Up-ramp: accept target=100, step=25, dwell=2 from IDLE -> duty 25/50/75/100, changing on every 2nd tick; done on the cycle after duty=100, then state HOLD.
REQ-035 Clamp and no overshoot: from HOLD at 100, target=300, step=100 -> target clamps to 256; duty 200 then 256, never above 256.
REQ-036 Down-ramp with zero fields: from HOLD at 256, target=10, step=0, dwell=0 -> duty decrements by 1 per tick to 10; done once.
REQ-037 Off priority: in HOLD at 80, off_req and cfg_valid in the same cycle -> no transfer; ramps to 0, enters IDLE with done; timer_final_value unchanged.
REQ-038 Reset mid-ramp: rst during RAMP at duty=60 -> next cycle duty=0, IDLE, cfg_ready=1 after release.
REQ-039 Handshake: cfg_valid held during RAMP -> cfg_ready=0, no latch; transfer occurs the first HOLD cycle.

Source files
------------

// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared types and default sizes for the PWM duty ramp controller.
package pwm_ramp_ctrl_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_TIMER_WIDTH = 15;
    localparam int DEF_DWELL_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/pwm_dwell_cnt.sv
// Counts PWM period ticks; pulses done_o on the tick that reaches term_i.
module pwm_dwell_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         tick_i,
    input  logic [W-1:0] term_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   nxt;

    assign nxt    = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
    assign done_o = tick_i && !clr_i && (nxt == {1'b0, term_i});

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = done_o ? '0 : nxt[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps the duty of an external PWM toward a configured target,
// one step per dwell of PWM periods, with an off request that ramps to 0.
module pwm_ramp_ctrl
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int TIMER_WIDTH = DEF_TIMER_WIDTH,
    parameter int DWELL_WIDTH = DEF_DWELL_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   period_tick,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [WIDTH:0]         cfg_target,
    input  logic [WIDTH-1:0]       cfg_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [TIMER_WIDTH-1:0] cfg_timer,
    input  logic                   off_req,
    output logic [WIDTH:0]         duty,
    output logic [TIMER_WIDTH-1:0] timer_final_value,
    output logic                   busy,
    output logic                   done
);

    localparam logic [WIDTH:0] DUTY_MAX = {1'b1, {WIDTH{1'b0}}};

    state_e                 state_q, state_d;
    logic [WIDTH:0]         duty_q, duty_d;
    logic [WIDTH:0]         target_q, target_d;
    logic [WIDTH-1:0]       step_q, step_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [TIMER_WIDTH-1:0] tfv_q, tfv_d;
    logic                   off_q, off_d;
    logic                   done_q, done_d;

    logic                   xfer;
    logic                   clr;
    logic                   step_hit;
    logic [WIDTH:0]         tgt_cl;
    logic [WIDTH:0]         step_ext;
    logic [WIDTH:0]         duty_nx;

    assign cfg_ready = (state_q != ST_RAMP) && !off_req;
    assign xfer      = cfg_valid && cfg_ready;
    assign tgt_cl    = (cfg_target > DUTY_MAX) ? DUTY_MAX : cfg_target;
    assign step_ext  = {1'b0, step_q};

    pwm_dwell_cnt #(.W(DWELL_WIDTH)) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .tick_i (period_tick && (state_q == ST_RAMP)),
        .term_i (dwell_q),
        .done_o (step_hit)
    );

    // Clamp each step at the target so the ramp never overshoots or wraps.
    always_comb begin
        duty_nx = duty_q;
        if (target_q > duty_q) begin
            if ((target_q - duty_q) <= step_ext) duty_nx = target_q;
            else duty_nx = duty_q + step_ext;
        end else if (target_q < duty_q) begin
            if ((duty_q - target_q) <= step_ext) duty_nx = target_q;
            else duty_nx = duty_q - step_ext;
        end
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        tfv_d    = tfv_q;
        off_d    = off_q;
        done_d   = 1'b0;
        clr      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (state_q == ST_HOLD && off_req) begin
                    target_d = '0;
                    off_d    = 1'b1;
                    state_d  = ST_RAMP;
                end else if (xfer) begin
                    target_d = tgt_cl;
                    step_d   = (cfg_step == '0) ? WIDTH'(1) : cfg_step;
                    dwell_d  = (cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg_dwell;
                    tfv_d    = cfg_timer;
                    off_d    = 1'b0;
                    clr      = 1'b1;
                    if (tgt_cl == duty_q) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RAMP;
                    end
                end
            end
            ST_RAMP: begin
                if (off_req) begin
                    target_d = '0;
                    off_d    = 1'b1;
                end else if (duty_q == target_q) begin
                    state_d = off_q ? ST_IDLE : ST_HOLD;
                    done_d  = 1'b1;
                    off_d   = 1'b0;
                end else if (step_hit) begin
                    duty_d = duty_nx;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            duty_q   <= '0;
            target_q <= '0;
            step_q   <= WIDTH'(1);
            dwell_q  <= DWELL_WIDTH'(1);
            tfv_q    <= '0;
            off_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
            tfv_q    <= tfv_d;
            off_q    <= off_d;
            done_q   <= done_d;
        end
    end

    assign duty              = duty_q;
    assign timer_final_value = tfv_q;
    assign busy              = (state_q == ST_RAMP);
    assign done              = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: ramps up/down, clamping, off, reset.
module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        period_tick;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [8:0]  cfg_target;
    logic [7:0]  cfg_step;
    logic [7:0]  cfg_dwell;
    logic [14:0] cfg_timer;
    logic        off_req;
    logic [8:0]  duty;
    logic [14:0] timer_final_value;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int dones  = 0;

    pwm_ramp_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .period_tick       (period_tick),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_target        (cfg_target),
        .cfg_step          (cfg_step),
        .cfg_dwell         (cfg_dwell),
        .cfg_timer         (cfg_timer),
        .off_req           (off_req),
        .duty              (duty),
        .timer_final_value (timer_final_value),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        period_tick = 1'b1;
        step();
        period_tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [8:0] t, input logic [7:0] s,
                       input logic [7:0] d, input logic [14:0] tm);
        cfg_target = t;
        cfg_step   = s;
        cfg_dwell  = d;
        cfg_timer  = tm;
        cfg_valid  = 1'b1;
        step();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; period_tick = 1'b0; cfg_valid = 1'b0; off_req = 1'b0;
        cfg_target = '0; cfg_step = '0; cfg_dwell = '0; cfg_timer = '0;
        step(); step();
        chk("rst_duty", 32'(duty), 0);
        chk("rst_tfv", 32'(timer_final_value), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(cfg_ready), 1);

        // up-ramp 0 -> 100, step 25, dwell 2
        cfg(9'd100, 8'd25, 8'd2, 15'd1234);
        chk("up_busy", 32'(busy), 1);
        chk("up_tfv", 32'(timer_final_value), 1234);
        chk("up_ready", 32'(cfg_ready), 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("up_half", 32'(duty), 32'(25 * (k - 1)));
            tick();
            chk("up_step", 32'(duty), 32'(25 * k));
        end
        chk("up_nodone", 32'(done), 0);
        step();
        chk("up_done", 32'(done), 1);
        chk("up_hold", 32'(busy), 0);
        step();
        chk("up_done1", 32'(done), 0);

        // clamp 300 -> 256, then hold cfg_valid through the ramp
        cfg(9'd300, 8'd100, 8'd1, 15'd500);
        chk("cl_busy", 32'(busy), 1);
        cfg_target = 9'd10; cfg_step = 8'd0; cfg_dwell = 8'd0;
        cfg_timer = 15'd77; cfg_valid = 1'b1;
        #1;
        chk("hs_ready0", 32'(cfg_ready), 0);
        tick();
        chk("cl_200", 32'(duty), 200);
        tick();
        chk("cl_256", 32'(duty), 256);
        tick();
        chk("cl_nowrap", 32'(duty), 256);
        chk("hs_nolatch", 32'(timer_final_value), 500);
        chk("cl_done", 32'(done), 1);
        chk("hs_ready1", 32'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        chk("hs_xfer_tfv", 32'(timer_final_value), 77);
        chk("hs_xfer_busy", 32'(busy), 1);

        // down-ramp 256 -> 10 by 1 per tick
        tick();
        chk("dn_255", 32'(duty), 255);
        dones = 0;
        for (int k = 0; k < 245; k++) begin
            tick();
            if (done) dones++;
        end
        chk("dn_10", 32'(duty), 10);
        for (int k = 0; k < 4; k++) begin
            step();
            if (done) dones++;
        end
        chk("dn_done_once", 32'(dones), 1);
        chk("dn_hold", 32'(busy), 0);

        // off priority from HOLD at 80
        cfg(9'd80, 8'd70, 8'd1, 15'd900);
        tick();
        chk("off_80", 32'(duty), 80);
        step();
        chk("off_hold", 32'(busy), 0);
        off_req = 1'b1; cfg_valid = 1'b1; cfg_target = 9'd200;
        cfg_timer = 15'd33;
        #1;
        chk("off_ready0", 32'(cfg_ready), 0);
        step();
        off_req = 1'b0; cfg_valid = 1'b0;
        chk("off_busy", 32'(busy), 1);
        chk("off_tfv", 32'(timer_final_value), 900);
        tick();
        chk("off_10", 32'(duty), 10);
        tick();
        chk("off_0", 32'(duty), 0);
        step();
        chk("off_done", 32'(done), 1);
        chk("off_idle", 32'(busy), 0);
        chk("off_tfv2", 32'(timer_final_value), 900);
        off_req = 1'b1;
        step();
        off_req = 1'b0;
        #1;
        chk("idle_off_ign", 32'(busy), 0);
        chk("idle_ready", 32'(cfg_ready), 1);

        // reset mid-ramp at 60
        cfg(9'd200, 8'd30, 8'd1, 15'd44);
        tick();
        tick();
        chk("rr_60", 32'(duty), 60);
        rst = 1'b1; period_tick = 1'b1; cfg_valid = 1'b1;
        step();
        rst = 1'b0; period_tick = 1'b0; cfg_valid = 1'b0;
        #1;
        chk("rr_duty", 32'(duty), 0);
        chk("rr_busy", 32'(busy), 0);
        chk("rr_tfv", 32'(timer_final_value), 0);
        chk("rr_ready", 32'(cfg_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
